// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared FSM/grant types and counter sizing for the SRAM arbiter
package sram_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {GNT_CPU, GNT_DBG} gnt_t;
    localparam int ACCESS_CYCLES_MAX = 15;
    localparam int CNT_W = $clog2(ACCESS_CYCLES_MAX + 1);
endpackage

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: 2-way round-robin grant with a last-grant register
module sram_rr_arbiter
    import sram_arb_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic i_cpu_req,
    input  logic i_dbg_req,
    input  logic i_update,
    input  gnt_t i_served,
    output logic o_valid,
    output gnt_t o_gnt
);
    gnt_t r_last;
    // last grant starts at DBG so the CPU wins the first tie
    always_ff @(posedge Clk) begin
        if (Reset) r_last <= GNT_DBG;
        else if (i_update) r_last <= i_served;
    end
    assign o_valid = i_cpu_req | i_dbg_req;
    assign o_gnt = (i_cpu_req && i_dbg_req) ? ((r_last == GNT_CPU) ? GNT_DBG : GNT_CPU)
                                            : (i_cpu_req ? GNT_CPU : GNT_DBG);
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between CPU and debug ports with fixed-timing accesses
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] Mem_ADDR,
    input  logic [DATA_W-1:0] Mem_DQ_in,
    output logic [DATA_W-1:0] Mem_DQ_out,
    output logic              Mem_DQ_oe,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              busy
);
    state_t            r_state;
    state_t            w_next;
    gnt_t              r_gnt;
    gnt_t              w_gnt;
    logic              w_valid;
    logic              w_done;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    sram_rr_arbiter u_rr (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_cpu_req (cpu_req),
        .i_dbg_req (dbg_req),
        .i_update  (w_done),
        .i_served  (r_gnt),
        .o_valid   (w_valid),
        .o_gnt     (w_gnt)
    );

    // state register; reset aborts any access so strobes release at the same edge
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // next state and SRAM strobe/ack decode from the registered state
    always_comb begin
        w_next    = r_state;
        Mem_CE    = 1'b1;
        Mem_UB    = 1'b1;
        Mem_LB    = 1'b1;
        Mem_OE    = 1'b1;
        Mem_WE    = 1'b1;
        Mem_DQ_oe = 1'b0;
        cpu_ack   = 1'b0;
        dbg_ack   = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            IDLE: w_next = w_valid ? ACCESS : IDLE;
            ACCESS: begin
                Mem_CE    = 1'b0;
                Mem_UB    = 1'b0;
                Mem_LB    = 1'b0;
                Mem_OE    = r_we;
                Mem_WE    = !r_we;
                Mem_DQ_oe = r_we;
                w_next    = (r_cnt == '0) ? DONE : ACCESS;
            end
            DONE: begin
                Mem_CE    = 1'b0;
                Mem_UB    = 1'b0;
                Mem_LB    = 1'b0;
                Mem_DQ_oe = r_we;
                cpu_ack   = (r_gnt == GNT_CPU);
                dbg_ack   = (r_gnt == GNT_DBG);
                w_done    = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // grant-time latching, access counter and read-data capture on the final strobe cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_gnt       <= GNT_CPU;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else if (r_state == IDLE && w_valid) begin
            r_gnt   <= w_gnt;
            r_we    <= (w_gnt == GNT_CPU) ? cpu_we : dbg_we;
            r_addr  <= (w_gnt == GNT_CPU) ? cpu_addr : dbg_addr;
            r_wdata <= (w_gnt == GNT_CPU) ? cpu_wdata : dbg_wdata;
            r_cnt   <= CNT_W'(ACCESS_CYCLES - 1);
        end else if (r_state == ACCESS) begin
            if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            else if (!r_we && r_gnt == GNT_CPU) r_cpu_rdata <= Mem_DQ_in;
            else if (!r_we) r_dbg_rdata <= Mem_DQ_in;
        end
    end

    assign Mem_ADDR   = r_addr;
    assign Mem_DQ_out = r_wdata;
    assign cpu_rdata  = r_cpu_rdata;
    assign dbg_rdata  = r_dbg_rdata;
    assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: table vectors, corner sequences and randomized traffic against a transaction model
module tb_sram_arbiter;
    localparam int AC = 2;

    logic        clk, rst, mem_clr;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [19:0] cpu_addr, dbg_addr, Mem_ADDR;
    logic [15:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
    logic        cpu_ack, dbg_ack, Mem_DQ_oe, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, busy;
    logic [15:0] Mem_DQ_in, Mem_DQ_out;

    logic        c1_req;
    logic [19:0] c1_addr, c1_maddr;
    logic [15:0] c1_rdata, c1_drdata, c1_dqin, c1_dqout;
    logic        c1_ack, c1_dack, c1_dqoe, c1_ce, c1_ub, c1_lb, c1_oe, c1_we, c1_busy;

    int checks = 0;
    int failures = 0;

    logic [15:0]  sram [0:255];
    logic [255:0] wr_v;

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(AC)) u_dut (
        .Clk(clk), .Reset(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .Mem_ADDR(Mem_ADDR), .Mem_DQ_in(Mem_DQ_in), .Mem_DQ_out(Mem_DQ_out), .Mem_DQ_oe(Mem_DQ_oe),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .busy(busy)
    );

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(1)) u_dut1 (
        .Clk(clk), .Reset(rst),
        .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr), .cpu_wdata(16'h0000),
        .cpu_rdata(c1_rdata), .cpu_ack(c1_ack),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(20'h0), .dbg_wdata(16'h0000),
        .dbg_rdata(c1_drdata), .dbg_ack(c1_dack),
        .Mem_ADDR(c1_maddr), .Mem_DQ_in(c1_dqin), .Mem_DQ_out(c1_dqout), .Mem_DQ_oe(c1_dqoe),
        .Mem_CE(c1_ce), .Mem_UB(c1_ub), .Mem_LB(c1_lb), .Mem_OE(c1_oe), .Mem_WE(c1_we),
        .busy(c1_busy)
    );

    function automatic logic [15:0] dflt(input logic [7:0] a);
        return 16'h1224 + {8'h00, a};
    endfunction

    assign Mem_DQ_in = wr_v[Mem_ADDR[7:0]] ? sram[Mem_ADDR[7:0]] : dflt(Mem_ADDR[7:0]);
    assign c1_dqin   = c1_maddr[15:0] ^ 16'h5A3C;

    always @(posedge clk) begin
        if (mem_clr) wr_v <= '0;
        else if (!Mem_CE && !Mem_WE) begin
            sram[Mem_ADDR[7:0]] <= Mem_DQ_out;
            wr_v[Mem_ADDR[7:0]] <= 1'b1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_port(input bit p, input bit r, input bit we, input logic [19:0] a, input logic [15:0] d);
        if (p) begin dbg_req = r; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
        else begin cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    endtask

    task automatic run_access(input bit port, input bit we, input logic [19:0] a, input logic [15:0] d,
                              output int lat, output int strobe, output bit bad, output bit hold,
                              output logic [15:0] seen);
        lat = -1; strobe = 0; bad = 0; hold = 0; seen = '0;
        set_port(port, 1'b1, we, a, d);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!(we ? Mem_OE : Mem_WE)) bad = 1;
            if (!we && Mem_DQ_oe) bad = 1;
            if (we && !Mem_WE) begin strobe++; seen = Mem_DQ_out; if (!Mem_DQ_oe) bad = 1; end
            if (!we && !Mem_OE) strobe++;
            if (port ? cpu_ack : dbg_ack) bad = 1;
            if (port ? dbg_ack : cpu_ack) begin lat = k; hold = Mem_DQ_oe; break; end
        end
        set_port(port, 1'b0, we, a, d);
        @(negedge clk);
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_cpu;
        logic [15:0] exp_dbg;
    } vec_t;

    vec_t tbl [7];

    bit          pend [2];
    bit          m_busy, m_port, m_we, m_last;
    logic [19:0] m_addr;
    logic [15:0] m_wd;
    logic [15:0] m_rd [2];
    logic [15:0] m_mem [0:255];
    bit          m_wr [0:255];
    int          n, idle_at, m_s, m_ack_at;

    initial begin
        int lat, strobe, cnt, order [4], at [4];
        bit bad, hold, both;
        logic [15:0] seen;

        tbl[0] = '{0, 0, 20'h00010, 16'h0000, 16'h1234, 16'h0000};
        tbl[1] = '{1, 1, 20'h00020, 16'hBEEF, 16'h1234, 16'h0000};
        tbl[2] = '{0, 0, 20'h00020, 16'h0000, 16'hBEEF, 16'h0000};
        tbl[3] = '{1, 0, 20'h00010, 16'h0000, 16'hBEEF, 16'h1234};
        tbl[4] = '{0, 1, 20'h00050, 16'h7777, 16'hBEEF, 16'h1234};
        tbl[5] = '{0, 0, 20'h00050, 16'h0000, 16'h7777, 16'h1234};
        tbl[6] = '{1, 0, 20'h00099, 16'h0000, 16'h7777, 16'h12BD};

        rst = 1; mem_clr = 1; c1_req = 0; c1_addr = '0;
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_DQ_oe, cpu_ack, dbg_ack, busy}, 9'b111110000);
        chk("reset_addr", Mem_ADDR, 0);
        chk("reset_rdata", {cpu_rdata, dbg_rdata}, 0);
        rst = 0; mem_clr = 0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, strobe, bad, hold, seen);
            chk($sformatf("vec%0d_latency", i), lat, AC + 1);
            chk($sformatf("vec%0d_strobe_cycles", i), strobe, AC);
            chk($sformatf("vec%0d_protocol", i), bad, 0);
            if (tbl[i].we) begin
                chk($sformatf("vec%0d_dq_out", i), seen, tbl[i].wdata);
                chk($sformatf("vec%0d_dq_hold", i), hold, 1);
            end
            chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, tbl[i].exp_cpu);
            chk($sformatf("vec%0d_dbg_rdata", i), dbg_rdata, tbl[i].exp_dbg);
            chk($sformatf("vec%0d_idle", i), busy, 0);
        end

        rst = 1; @(negedge clk); rst = 0; @(negedge clk);
        set_port(0, 1, 0, 20'h00040, '0);
        set_port(1, 1, 0, 20'h00041, '0);
        cnt = 0; both = 0;
        for (int k = 1; k <= 40 && cnt < 4; k++) begin
            @(negedge clk);
            if (cpu_ack && dbg_ack) both = 1;
            if (cpu_ack || dbg_ack) begin order[cnt] = dbg_ack ? 1 : 0; at[cnt] = k; cnt++; end
        end
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);
        @(negedge clk);
        chk("rr_ack_count", cnt, 4);
        chk("rr_no_double_ack", both, 0);
        if (cnt == 4) begin
            chk("rr_first_latency", at[0], AC + 1);
            for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), order[i], i % 2);
            for (int i = 1; i < 4; i++) chk($sformatf("rr_spacing%0d", i), at[i] - at[i-1], AC + 2);
        end
        chk("rr_cpu_rdata", cpu_rdata, dflt(8'h40));
        chk("rr_dbg_rdata", dbg_rdata, dflt(8'h41));

        set_port(0, 1, 1, 20'h00030, 16'hCAFE);
        @(negedge clk);
        chk("abort_we_low", {Mem_WE, Mem_DQ_oe}, 2'b01);
        rst = 1; set_port(0, 0, 0, '0, '0);
        @(negedge clk);
        chk("abort_ctrl", {Mem_WE, Mem_OE, Mem_CE, Mem_DQ_oe, cpu_ack, dbg_ack, busy}, 7'b1110000);
        chk("abort_addr", Mem_ADDR, 0);
        rst = 0;
        cnt = 0;
        repeat (5) begin @(negedge clk); if (cpu_ack || dbg_ack || busy) cnt++; end
        chk("abort_no_ack", cnt, 0);

        c1_addr = 20'h00077; c1_req = 1;
        lat = -1; strobe = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!c1_oe) strobe++;
            if (c1_ack) begin lat = k; break; end
        end
        c1_req = 0;
        @(negedge clk);
        chk("ac1_latency", lat, 2);
        chk("ac1_oe_cycles", strobe, 1);
        chk("ac1_rdata", c1_rdata, 16'h0077 ^ 16'h5A3C);
        chk("ac1_dbg_rdata", c1_drdata, 0);

        rst = 1; @(negedge clk); rst = 0;
        n = 0; idle_at = 1; m_busy = 0; m_last = 1; m_port = 0; m_we = 0; m_addr = '0; m_wd = '0;
        m_rd[0] = '0; m_rd[1] = '0; pend[0] = 0; pend[1] = 0; m_s = 0; m_ack_at = 0;
        for (int i = 0; i < 256; i++) m_wr[i] = 0;
        for (int it = 0; it < 600; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (m_busy && m_port == p[0])
                    set_port(p[0], 1, 1'($urandom), 20'($urandom), 16'($urandom));
                else if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    pend[p] = 1;
                    set_port(p[0], 1, 1'($urandom), 20'($urandom_range(0, 15)), 16'($urandom));
                end else if (!pend[p])
                    set_port(p[0], 0, 1'($urandom), 20'($urandom), 16'($urandom));
            end
            if (!m_busy && idle_at <= n + 1 && (pend[0] || pend[1])) begin
                m_port = (pend[0] && pend[1]) ? !m_last : !pend[0];
                m_busy = 1;
                m_we   = m_port ? dbg_we : cpu_we;
                m_addr = m_port ? dbg_addr : cpu_addr;
                m_wd   = m_port ? dbg_wdata : cpu_wdata;
                m_s = n + 1; m_ack_at = n + 1 + AC; idle_at = m_ack_at + 2; m_last = m_port;
            end
            @(negedge clk);
            n++;
            chk("rnd_busy", busy, m_busy && n >= m_s && n <= m_ack_at);
            chk("rnd_cpu_ack", cpu_ack, m_busy && n == m_ack_at && !m_port);
            chk("rnd_dbg_ack", dbg_ack, m_busy && n == m_ack_at && m_port);
            if (m_busy && n == m_ack_at) begin
                if (m_we) begin m_mem[m_addr[7:0]] = m_wd; m_wr[m_addr[7:0]] = 1; end
                else m_rd[m_port] = m_wr[m_addr[7:0]] ? m_mem[m_addr[7:0]] : dflt(m_addr[7:0]);
                pend[m_port] = 0;
                m_busy = 0;
            end
            chk("rnd_cpu_rdata", cpu_rdata, m_rd[0]);
            chk("rnd_dbg_rdata", dbg_rdata, m_rd[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
